// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Single-outstanding-request instruction fetch stage. It issues a word
//   read to instruction memory at PC, registers the returned word into INST,
//   and holds it for the decoder until the downstream releases it (STALL=0).
//   A branch/jump redirect that arrives while a request is still outstanding
//   is parked in a pending-target register until the memory acknowledges
//   the stale request. The stale data is then dropped and fetch resumes at
//   the parked target.
//
// Optional feature (compile-time macro FETCH_MISALIGN_TRAP_EN):
//   defined   : an accepted redirect whose TARGET[1:0] != 0 sets MISALIGN,
//               invalidates INST and parks the unit in HALT (no requests)
//               until reset.
//   undefined : TARGET[1:0] are forced to 2'b00, MISALIGN is tied low and
//               there is no HALT state.
//
// Parameters:
//   RESET_PC   - address of the first fetch after reset
//   NOP_INST   - value presented on INST while INST_VALID=0
//
// Ports:
//   CLK         in   1   clock, all state updates on the rising edge
//   RST         in   1   synchronous active-high reset
//   IMEM_REQ    out  1   instruction-memory read request
//   IMEM_ADDR   out  32  word address of the current request
//   IMEM_ACK    in   1   IMEM_RDATA is valid this cycle
//   IMEM_RDATA  in   32  instruction word from memory
//   STALL       in   1   downstream not ready, hold the current instruction
//   REDIRECT    in   1   taken branch/jump, next PC is TARGET
//   TARGET      in   32  redirect address
//   INST        out  32  registered instruction word
//   INST_VALID  out  1   INST holds a fetched instruction
//   PC          out  32  address of INST
//   PC_PLUS4    out  32  PC+4 (combinational, wraps modulo 2^32)
//   MISALIGN    out  1   sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] TARGET,
  output logic [31:0] INST,
  output logic        INST_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        MISALIGN
);

  // REQ   : request outstanding at r_pc, data will be kept
  // DRAIN : request outstanding at r_pc, data will be dropped (redirect seen)
  // HOLD  : INST valid, waiting for the downstream to release it
  // HALT  : misaligned redirect trapped, idle until reset
  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_inst_valid;
  logic [31:0] r_pend;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_tgt_bad;
  logic        w_accept;
  logic        w_trap;
  logic        w_imem_req;

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_target  = TARGET;
  assign w_tgt_bad = |TARGET[1:0];
`else
  // Low address bits are dropped so a misaligned target fetches the
  // enclosing word instead of trapping.
  assign w_target  = TARGET & 32'hFFFF_FFFC;
  assign w_tgt_bad = 1'b0;
`endif

  // A redirect is only honoured while a request is in flight or when the
  // held instruction is being released; a stalled HOLD ignores it.
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      S_REQ:   w_accept = REDIRECT;
      S_DRAIN: w_accept = REDIRECT;
      S_HOLD:  w_accept = REDIRECT && !STALL;
      default: w_accept = 1'b0;
    endcase
  end

  assign w_trap = w_accept && w_tgt_bad;

  // ---- state register -----------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state logic ---------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        // Redirect with simultaneous ACK restarts immediately in REQ.
        if (REDIRECT && !IMEM_ACK) begin
          w_state_nxt = S_DRAIN;
        end else if (!REDIRECT && IMEM_ACK) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (IMEM_ACK) begin
          w_state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (!STALL) begin
          w_state_nxt = S_REQ;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
`endif
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (w_trap) begin
      w_state_nxt = S_HALT;
    end
`endif
  end

  // ---- output logic -------------------------------------------------------
  always_comb begin
    w_imem_req = 1'b0;
    case (r_state)
      S_REQ:   w_imem_req = 1'b1;
      S_DRAIN: w_imem_req = 1'b1;
      default: w_imem_req = 1'b0;
    endcase
    // No request may be visible while reset is asserted, even though the
    // state register may already read REQ.
    if (RST) begin
      w_imem_req = 1'b0;
    end
  end

  assign IMEM_REQ   = w_imem_req;
  // The address is simply PC: it cannot move while a request is pending,
  // because PC only changes on ACK or when leaving HOLD.
  assign IMEM_ADDR  = r_pc;
  assign INST       = r_inst;
  assign INST_VALID = r_inst_valid;
  assign PC         = r_pc;
  assign PC_PLUS4   = w_pc_plus4;

  // ---- fetch datapath -----------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc         <= RESET_PC;
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
      r_pend       <= 32'h0000_0000;
    end else if (w_trap) begin
      r_inst       <= NOP_INST;
      r_inst_valid <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (REDIRECT) begin
            // Returned data (if any) belongs to the wrong path.
            if (IMEM_ACK) begin
              r_pc <= w_target;
            end else begin
              r_pend <= w_target;
            end
          end else if (IMEM_ACK) begin
            r_inst       <= IMEM_RDATA;
            r_inst_valid <= 1'b1;
          end
        end
        S_DRAIN: begin
          // The newest redirect always wins over the parked one.
          if (REDIRECT) begin
            r_pend <= w_target;
          end
          if (IMEM_ACK) begin
            r_pc <= REDIRECT ? w_target : r_pend;
          end
        end
        S_HOLD: begin
          if (!STALL) begin
            r_pc         <= REDIRECT ? w_target : w_pc_plus4;
            r_inst       <= NOP_INST;
            r_inst_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_misalign <= 1'b0;
    end else if (w_trap) begin
      r_misalign <= 1'b1;
    end
  end

  assign MISALIGN = r_misalign;
`else
  assign MISALIGN = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] TARGET;
  logic [31:0] INST;
  logic        INST_VALID;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic        MISALIGN;

  always #5 CLK = ~CLK;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IMEM_REQ  (IMEM_REQ),
    .IMEM_ADDR (IMEM_ADDR),
    .IMEM_ACK  (IMEM_ACK),
    .IMEM_RDATA(IMEM_RDATA),
    .STALL     (STALL),
    .REDIRECT  (REDIRECT),
    .TARGET    (TARGET),
    .INST      (INST),
    .INST_VALID(INST_VALID),
    .PC        (PC),
    .PC_PLUS4  (PC_PLUS4),
    .MISALIGN  (MISALIGN)
  );

  // Memory contents: every word is its own address tagged with a constant.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign IMEM_RDATA = memf(IMEM_ADDR);

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the fetch unit must show, by rule.
  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_valid;
  bit          m_discard;     // outstanding request's data must be dropped
  logic [31:0] m_next_after;  // where fetch goes once the dropped data returns
  bit          m_halt;
  bit          m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fix_tgt(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic bit tgt_bad(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_compare();
    bit exp_req;
    if (!m_known) return;
    exp_req = !RST && !m_valid && !m_halt;
    chk("imem_req", {31'b0, IMEM_REQ}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", IMEM_ADDR, m_pc);
    chk("inst_valid", {31'b0, INST_VALID}, {31'b0, m_valid});
    chk("inst", INST, m_valid ? m_inst : NOP);
    if (!m_halt) begin
      chk("pc", PC, m_pc);
      chk("pc_plus4", PC_PLUS4, m_pc + 32'd4);
    end
    chk("misalign", {31'b0, MISALIGN}, {31'b0, m_mis});
  endtask

  task automatic model_step(input bit rst, input bit ack, input bit stall,
                            input bit redir, input logic [31:0] tgt);
    if (rst) begin
      m_known = 1'b1; m_pc = 32'h0; m_inst = NOP; m_valid = 1'b0;
      m_discard = 1'b0; m_next_after = 32'h0; m_halt = 1'b0; m_mis = 1'b0;
      return;
    end
    if (!m_known || m_halt) return;
    if (m_valid) begin
      if (!stall) begin
        if (redir && tgt_bad(tgt)) begin
          m_halt = 1'b1; m_mis = 1'b1; m_valid = 1'b0;
        end else begin
          m_pc = redir ? fix_tgt(tgt) : m_pc + 32'd4;
          m_valid = 1'b0;
        end
      end
    end else if (redir) begin
      if (tgt_bad(tgt)) begin
        m_halt = 1'b1; m_mis = 1'b1; m_valid = 1'b0;
      end else if (ack) begin
        m_pc = fix_tgt(tgt);
        m_discard = 1'b0;
      end else begin
        m_discard = 1'b1;
        m_next_after = fix_tgt(tgt);
      end
    end else if (ack) begin
      if (m_discard) begin
        m_pc = m_next_after;
        m_discard = 1'b0;
      end else begin
        m_valid = 1'b1;
        m_inst = memf(m_pc);
      end
    end
  endtask

  // One clock: drive at the falling edge, compare mid-cycle, advance model
  // at the rising edge, return at the next falling edge.
  task automatic cyc(input bit rst, input bit ack, input bit stall,
                     input bit redir, input logic [31:0] tgt);
    RST = rst; IMEM_ACK = ack; STALL = stall; REDIRECT = redir; TARGET = tgt;
    #1;
    model_compare();
    @(posedge CLK);
    model_step(rst, ack, stall, redir, tgt);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; IMEM_ACK = 1'b0; STALL = 1'b0; REDIRECT = 1'b0; TARGET = 32'h0;
    @(negedge CLK);

    // Reset, with a stray ACK during reset that must be ignored.
    cyc(1, 0, 0, 0, 32'h0);
    cyc(1, 1, 0, 0, 32'h0);
    chk("rst_inst", INST, 32'h0000_0013);
    chk("rst_valid", {31'b0, INST_VALID}, 32'h0);
    chk("rst_req", {31'b0, IMEM_REQ}, 32'h0);
    chk("rst_pc", PC, 32'h0);

    // Sequential fetch 0x0, 0x4, 0x8.
    cyc(0, 1, 0, 0, 32'h0);
    chk("f0_valid", {31'b0, INST_VALID}, 32'h1);
    chk("f0_inst", INST, 32'hA5A5_0000);
    chk("f0_pc", PC, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    chk("f1_addr", IMEM_ADDR, 32'h4);
    chk("f1_valid", {31'b0, INST_VALID}, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    chk("f2_addr", IMEM_ADDR, 32'h8);

    // HOLD with STALL for three cycles; redirect must be ignored.
    cyc(0, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 32'h100);
    chk("stall_pc", PC, 32'h8);
    chk("stall_inst", INST, 32'hA5A5_0008);
    chk("stall_valid", {31'b0, INST_VALID}, 32'h1);
    cyc(0, 0, 0, 0, 32'h0);
    chk("stall_next_addr", IMEM_ADDR, 32'hC);

    // Redirect in REQ with ACK three cycles late.
    cyc(0, 0, 0, 1, 32'h200);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    chk("drain_addr", IMEM_ADDR, 32'hC);
    chk("drain_valid", {31'b0, INST_VALID}, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    chk("drain_next_addr", IMEM_ADDR, 32'h200);
    chk("drain_drop_valid", {31'b0, INST_VALID}, 32'h0);

    // Redirect and ACK in the same cycle.
    cyc(0, 1, 0, 1, 32'h300);
    chk("redir_ack_addr", IMEM_ADDR, 32'h300);
    chk("redir_ack_valid", {31'b0, INST_VALID}, 32'h0);

    // Second redirect while draining replaces the first.
    cyc(0, 0, 0, 1, 32'h400);
    cyc(0, 0, 0, 1, 32'h500);
    cyc(0, 1, 0, 0, 32'h0);
    chk("drain_overwrite", IMEM_ADDR, 32'h500);

    // PC wrap at the top of the address space.
    cyc(0, 1, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS4, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    chk("wrap_inst", INST, 32'h5A5A_FFFC);
    cyc(0, 0, 0, 0, 32'h0);
    chk("wrap_addr", IMEM_ADDR, 32'h0);

    // Mixed traffic, aligned targets only; checked against the model.
    for (int i = 0; i < 60; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) == 0), 32'($urandom_range(0, 1023)) << 2);
    end

    // Reset while a redirect is draining.
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h600);
    cyc(1, 1, 0, 0, 32'h0);
    chk("rdrain_req", {31'b0, IMEM_REQ}, 32'h0);
    chk("rdrain_inst", INST, 32'h0000_0013);
    chk("rdrain_valid", {31'b0, INST_VALID}, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    chk("rdrain_req_after", {31'b0, IMEM_REQ}, 32'h1);
    chk("rdrain_addr", IMEM_ADDR, 32'h0);

    // Misaligned redirect target.
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 0, 0, 1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", {31'b0, MISALIGN}, 32'h1);
    chk("mis_req", {31'b0, IMEM_REQ}, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    chk("mis_req_held", {31'b0, IMEM_REQ}, 32'h0);
    chk("mis_valid", {31'b0, INST_VALID}, 32'h0);
`else
    chk("mis_addr", IMEM_ADDR, 32'h100);
    chk("mis_flag", {31'b0, MISALIGN}, 32'h0);
    cyc(0, 1, 0, 0, 32'h0);
    chk("mis_inst", INST, 32'hA5A5_0100);
`endif
    cyc(0, 0, 0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
